// File: rtl/uart_tx_fifo.sv
// 8-bit UART transmitter (start, 8 data LSB-first, optional parity, stop) fed by a small byte FIFO.
// The line advances one bit per clken pulse; Tx comes straight from a flop.
module uart_tx_fifo #(
    parameter int FIFO_AW    = 2,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       clken,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       tx_busy,
    output logic       Tx
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t             state_q, state_d;
    logic [7:0]         mem_q [DEPTH];
    logic [7:0]         mem_d [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         bit_pos_q, bit_pos_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               full_now;
    logic               push;
    logic               pop;

    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        shift_d    = shift_q;
        bit_pos_d  = bit_pos_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        pop        = 1'b0;

        // Full is judged on the registered count, so a pop on the same edge never frees room for this write.
        full_now = (count_q == DEPTH_C);
        push     = wr_en && !full_now;
        if (wr_en && full_now) begin
            overflow_d = 1'b1;
        end

        if (clken) begin
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        pop       = 1'b1;
                        shift_d   = mem_q[rd_ptr_q];
                        tx_d      = 1'b0;
                        busy_d    = 1'b1;
                        bit_pos_d = 3'd0;
                        state_d   = S_DATA;
                    end else begin
                        tx_d   = 1'b1;
                        busy_d = 1'b0;
                    end
                end
                S_DATA: begin
                    tx_d      = shift_q[bit_pos_q];
                    bit_pos_d = bit_pos_q + 3'd1;
                    if (bit_pos_q == 3'd7) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    tx_d    = (^shift_q) ^ PARITY_ODD;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            shift_q    <= 8'h00;
            bit_pos_q  <= 3'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            shift_q    <= shift_d;
            bit_pos_q  <= bit_pos_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign overflow = overflow_q;
    assign tx_busy  = busy_q;
    assign Tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (no parity, even, odd) share stimulus and are compared
// every cycle against a frame/queue reference model, plus a 16x-oversampling loopback receiver.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       clken;
    logic [7:0] din;
    logic       wr_en;
    logic [2:0] full_o, empty_o, ovf_o, busy_o, tx_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.FIFO_AW(2), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
        .clk_50m(clk), .rst(rst), .clken(clken), .din(din), .wr_en(wr_en),
        .full(full_o[0]), .empty(empty_o[0]), .overflow(ovf_o[0]), .tx_busy(busy_o[0]), .Tx(tx_o[0]));
    uart_tx_fifo #(.FIFO_AW(2), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
        .clk_50m(clk), .rst(rst), .clken(clken), .din(din), .wr_en(wr_en),
        .full(full_o[1]), .empty(empty_o[1]), .overflow(ovf_o[1]), .tx_busy(busy_o[1]), .Tx(tx_o[1]));
    uart_tx_fifo #(.FIFO_AW(2), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut2 (
        .clk_50m(clk), .rst(rst), .clken(clken), .din(din), .wr_en(wr_en),
        .full(full_o[2]), .empty(empty_o[2]), .overflow(ovf_o[2]), .tx_busy(busy_o[2]), .Tx(tx_o[2]));

    // Reference model: a byte queue plus the bit list of the frame currently on the line.
    logic [7:0]  mq [3][4];
    int          mcnt [3];
    logic [10:0] fb [3];
    int          flen [3];
    int          fidx [3];
    logic        mtx [3];
    logic        mbusy [3];
    logic        movf [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0; flen[k] = 0; fidx[k] = 0; fb[k] = '0;
            mtx[k] = 1'b1; mbusy[k] = 1'b0; movf[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic ce, input logic we, input logic [7:0] d);
        for (int k = 0; k < 3; k++) begin
            logic       full_b;
            logic [7:0] b;
            full_b = (mcnt[k] == 4);
            if (ce) begin
                if (fidx[k] < flen[k]) begin
                    mtx[k] = fb[k][fidx[k]];
                    fidx[k]++;
                    mbusy[k] = 1'b1;
                end else if (mcnt[k] > 0) begin
                    b = mq[k][0];
                    for (int j = 0; j < 3; j++) mq[k][j] = mq[k][j+1];
                    mcnt[k]--;
                    fb[k] = '0;
                    fb[k][8:1] = b;
                    if (k == 0) begin
                        fb[k][9] = 1'b1;
                        flen[k] = 10;
                    end else begin
                        fb[k][9]  = (^b) ^ (k == 2);
                        fb[k][10] = 1'b1;
                        flen[k] = 11;
                    end
                    mtx[k] = 1'b0; fidx[k] = 1; mbusy[k] = 1'b1;
                end else begin
                    mtx[k] = 1'b1; mbusy[k] = 1'b0;
                end
            end
            if (we) begin
                if (full_b) movf[k] = 1'b1;
                else begin
                    mq[k][mcnt[k]] = d;
                    mcnt[k]++;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: got %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk("tx", k, {7'd0, tx_o[k]}, {7'd0, mtx[k]});
            chk("tx_busy", k, {7'd0, busy_o[k]}, {7'd0, mbusy[k]});
            chk("full", k, {7'd0, full_o[k]}, {7'd0, (mcnt[k] == 4)});
            chk("empty", k, {7'd0, empty_o[k]}, {7'd0, (mcnt[k] == 0)});
            chk("overflow", k, {7'd0, ovf_o[k]}, {7'd0, movf[k]});
        end
    endtask

    task automatic cyc(input logic ce, input logic we, input logic [7:0] d);
        clken = ce; wr_en = we; din = d;
        model_edge(ce, we, d);
        @(posedge clk); #1;
        clken = 1'b0; wr_en = 1'b0;
        check_all();
    endtask

    // Oversampling receiver on dut0: samples each bit 8 cycles into its 16-cycle period.
    logic       rx_en = 1'b0;
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_buf [8];
    int         rx_n = 0;
    int         rx_ferr = 0;

    always @(posedge clk) begin
        if (!rx_en) begin
            rx_act <= 1'b0;
        end else if (!rx_act) begin
            if (tx_o[0] == 1'b0) begin
                rx_act <= 1'b1;
                rx_cnt <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            for (int i = 0; i < 8; i++) begin
                if (rx_cnt == 16 * (i + 1) + 8) rx_sh[i] <= tx_o[0];
            end
            if (rx_cnt == 152) begin
                rx_act <= 1'b0;
                if (tx_o[0] !== 1'b1) rx_ferr <= rx_ferr + 1;
                if (rx_n < 8) rx_buf[rx_n] <= rx_sh;
                rx_n <= rx_n + 1;
            end
        end
    end

    logic [7:0] lb_bytes [4];

    initial begin
        rst = 1'b1; clken = 1'b0; wr_en = 1'b0; din = 8'h00;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_all();
        rst = 1'b0;

        // Single byte 0x55, one clken every 16 cycles.
        cyc(1'b0, 1'b1, 8'h55);
        for (int i = 0; i < 16 * 12; i++) cyc((i % 16) == 0, 1'b0, 8'h00);
        chk("idle_after_55", 0, {7'd0, busy_o[0]}, 8'd0);

        // 0x07 with clken every cycle: 10th clken is the parity slot for dut1/dut2.
        cyc(1'b0, 1'b1, 8'h07);
        for (int i = 1; i <= 13; i++) begin
            cyc(1'b1, 1'b0, 8'h00);
            if (i == 10) begin
                chk("parity_even", 1, {7'd0, tx_o[1]}, 8'd1);
                chk("parity_odd", 2, {7'd0, tx_o[2]}, 8'd0);
                chk("stop_nopar", 0, {7'd0, tx_o[0]}, 8'd1);
            end
        end

        // Fill to full, then one dropped write.
        cyc(1'b0, 1'b1, 8'hA1);
        cyc(1'b0, 1'b1, 8'hB2);
        cyc(1'b0, 1'b1, 8'hC3);
        cyc(1'b0, 1'b1, 8'hD4);
        chk("full_after_4", 0, {7'd0, full_o[0]}, 8'd1);
        cyc(1'b0, 1'b1, 8'hE5);
        chk("overflow_5th", 0, {7'd0, ovf_o[0]}, 8'd1);
        for (int i = 0; i < 3 * 47; i++) cyc((i % 3) == 0, 1'b0, 8'h00);

        // Write on the same edge as an idle clken: start bit waits for the next clken.
        cyc(1'b1, 1'b1, 8'h9E);
        chk("same_edge_no_start", 0, {7'd0, tx_o[0]}, 8'd1);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        chk("same_edge_next_start", 0, {7'd0, tx_o[0]}, 8'd0);
        for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 8'h00);

        // Async reset during data bit 3 of 0x3C with two bytes queued.
        cyc(1'b0, 1'b1, 8'h3C);
        cyc(1'b0, 1'b1, 8'h11);
        cyc(1'b0, 1'b1, 8'h22);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h00);
        chk("busy_before_rst", 0, {7'd0, busy_o[0]}, 8'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) cyc((i % 2) == 0, 1'b0, 8'h00);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 8'($urandom));
        end
        for (int i = 0; i < 70; i++) cyc(1'b1, 1'b0, 8'h00);

        // Loopback: 16-cycle bit period into the oversampling receiver.
        lb_bytes[0] = 8'h00; lb_bytes[1] = 8'hFF; lb_bytes[2] = 8'h5A; lb_bytes[3] = 8'h81;
        rx_en = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, lb_bytes[i]);
        for (int i = 0; i < 720; i++) cyc((i % 16) == 0, 1'b0, 8'h00);
        chk("rx_count", 0, 8'(rx_n), 8'd4);
        chk("rx_framing", 0, 8'(rx_ferr), 8'd0);
        for (int i = 0; i < 4; i++) chk("rx_byte", 0, rx_buf[i], lb_bytes[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

UART transmitter with a 4-entry byte FIFO. It is the transmit-side counterpart of the team's 8N1 UART receiver and runs in the same `clk_50m` domain. It accepts bytes from the host logic via a write strobe and serialises them LSB-first on `Tx`: start bit, 8 data bits, optional parity bit, one stop bit. Frames go out back-to-back while the FIFO holds data.

## Interface
Parameters:
- `FIFO_AW`, 2: FIFO address width; depth = 2^FIFO_AW entries (default 4).
- `PARITY_EN`, 0: 1 inserts a parity bit after data bit 7.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.

Ports:
- `clk_50m`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `clken`  in  1  single-cycle pulse, one per bit period (1x baud, not 16x).
- `din`  in  8  byte to transmit.
- `wr_en`  in  1  write strobe; `din` is captured on the edge where `wr_en`=1 and `full`=0.
- `full`  out  1  FIFO holds 2^FIFO_AW bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `overflow`  out  1  sticky; set when a write arrives while `full`=1; cleared only by `rst`.
- `tx_busy`  out  1  a frame bit (start through stop) is currently on the line.
- `Tx`  out  1  serial line; idles high.

## Operation
- Reset values:
  - `Tx`=1, `tx_busy`=0, `full`=0, `empty`=1, `overflow`=0.
  - state=IDLE, FIFO pointers and count=0.
  - Reset is async: asserting `rst` mid-frame forces `Tx` high immediately and flushes the FIFO.
- FIFO:
  - Registered count of width FIFO_AW+1; read and write pointers wrap modulo depth.
  - `full` = (count == depth); `empty` = (count == 0).
  - A write while full is dropped and sets `overflow`. Contents are unchanged.
  - Simultaneous pop and write when full: the pop occurs and the write is dropped (`full` is evaluated before the pop).
  - Simultaneous pop and write when not full: both take effect; count is unchanged.
- State machine: IDLE, DATA, PARITY, STOP. Transitions occur only on edges with `clken`=1. Each state registers the next line bit into `Tx`.
  - IDLE, FIFO non-empty: pop the head into the shift register, `Tx`<=0 (start bit), `tx_busy`<=1, bit_pos<=0, go to DATA.
  - IDLE, FIFO empty: `Tx`<=1, `tx_busy`<=0; stay in IDLE.
  - DATA: `Tx`<=shift[bit_pos], bit_pos<=bit_pos+1. When bit_pos==7, go to PARITY if `PARITY_EN`, else STOP.
  - PARITY: `Tx`<= ^shift (even) or ~^shift (odd); go to STOP.
  - STOP: `Tx`<=1; go to IDLE. The stop bit lasts until the next `clken`. That IDLE `clken` either emits the next start bit (back-to-back) or drops `tx_busy`.
- With `clken`=0, all state, `Tx`, and `tx_busy` hold. FIFO writes are still accepted.
- A byte written into an empty FIFO on the same edge as an IDLE `clken` is not popped on that edge. Its start bit is driven on the following `clken`.

## Timing
- Frame length:
  - 10 `clken` periods (start + 8 + stop) with no parity.
  - 11 periods with `PARITY_EN`=1.
- Latency: the start bit appears on the first `clken` edge after a write into an empty, idle transmitter, at most one bit period later.
- Back-to-back frames: no idle gap; stop is exactly one period, then the next start bit.
- `tx_busy` rises on the start-bit edge and falls on the `clken` edge that ends the stop bit when the FIFO is empty.
- `Tx` is driven directly from a flop (glitch-free).
- `full`, `empty`, and `overflow` update one cycle after the causing edge; they are registered.

## Test plan
- Single byte 0x55, `clken` every 16 cycles, no parity:
  - `Tx` per period = 0,1,0,1,0,1,0,1,0,1.
  - `tx_busy` is high for 10 periods, then low.
  - `empty` returns to 1 after the pop.
- `PARITY_EN`=1, even, byte 0x07: data 1,1,1,0,0,0,0,0, parity bit 1, stop 1. With `PARITY_ODD`=1, the parity bit is 0.
- Write 0xA1, 0xB2, 0xC3, 0xD4, 0xE5 on consecutive cycles with no `clken`:
  - `full`=1 after the 4th write.
  - The 5th write is dropped and `overflow`=1.
  - After enabling `clken`, 4 contiguous frames A1, B2, C3, D4 go out with no idle gap.
- Assert `rst` during data bit 3 of frame 0x3C with 2 bytes queued:
  - `Tx`=1 immediately; `empty`=1, `tx_busy`=0, `overflow`=0.
  - After release with no writes, `Tx` stays 1.
- Write on the same edge as an IDLE `clken` with the FIFO empty: the start bit appears on the next `clken`, not the current one.
- Loopback into the team's receiver (receiver `clken` at 16x, transmitter `clken` every 16th pulse): send 0x00, 0xFF, 0x5A, 0x81. Each byte is received intact with `ready` pulsing once per byte.
